// File: rtl/sprite_fetch_if.sv
// -----------------------------------------------------------------------------
// sprite_fetch_if
// Memory-side bus of the sprite fetcher: the secondary OAM read port and the
// CHR request/acknowledge port. Signal names keep the fetcher's point of view
// (o_* driven by the fetcher, i_* driven by the memories).
//   o_temp_addr  secondary OAM address {slot, field}
//   i_temp_data  secondary OAM read data, one ce cycle after the address
//   o_chr_req    CHR read request (level)
//   o_chr_addr   CHR byte address
//   i_chr_ack    CHR data valid, held until sampled on a ce cycle
//   i_chr_data   CHR read data
// Modports: master = fetcher, slave = memory side.
// -----------------------------------------------------------------------------
interface sprite_fetch_if #(
   parameter int CHR_AW = 14
);
   logic [4:0]        o_temp_addr;
   logic [7:0]        i_temp_data;
   logic              o_chr_req;
   logic [CHR_AW-1:0] o_chr_addr;
   logic              i_chr_ack;
   logic [7:0]        i_chr_data;

   modport master (
      output o_temp_addr,
      input  i_temp_data,
      output o_chr_req,
      output o_chr_addr,
      input  i_chr_ack,
      input  i_chr_data
   );

   modport slave (
      input  o_temp_addr,
      output i_temp_data,
      input  o_chr_req,
      input  o_chr_addr,
      output i_chr_ack,
      output i_chr_data
   );
endinterface

// File: rtl/sprite_fetch.sv
// -----------------------------------------------------------------------------
// sprite_fetch
// Feeds the 8-entry sprite shifter chain during the sprite-fetch window. For
// every secondary OAM slot it reads Y, tile, attr and X, fetches the two
// pattern planes from CHR (skipped for empty slots, Y == 0xFF), applies the
// flip/size rules and pushes one 27-bit load word. Slot 0 is pushed first.
// Ports:
//   clk, i_rst_n     clock, asynchronous active-low reset
//   ce               clock enable for all state and strobes
//   i_start          start pulse (ignored while busy)
//   i_obj_size       1 = 8x16 sprites
//   i_spr_table      pattern table select in 8x8 mode
//   bus              secondary OAM + CHR memory bus (master side)
//   o_load           4'b1111 while the current slot's word is presented
//   o_load_in        {pix1, pix2, x, pal, prio}
//   o_busy           high from accepted start until done
//   o_done           one ce cycle after the last slot is loaded
// -----------------------------------------------------------------------------
module sprite_fetch #(
   parameter int NUM_SLOTS = 8,
   parameter int CHR_AW    = 14
) (
   input  logic                  clk,
   input  logic                  i_rst_n,
   input  logic                  ce,
   input  logic                  i_start,
   input  logic                  i_obj_size,
   input  logic                  i_spr_table,
   sprite_fetch_if.master        bus,
   output logic [3:0]            o_load,
   output logic [26:0]           o_load_in,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_RD_Y     = 4'd1;
   localparam logic [3:0] S_RD_TILE  = 4'd2;
   localparam logic [3:0] S_RD_ATTR  = 4'd3;
   localparam logic [3:0] S_RD_X     = 4'd4;
   localparam logic [3:0] S_FETCH_LO = 4'd5;
   localparam logic [3:0] S_FETCH_HI = 4'd6;
   localparam logic [3:0] S_LOAD     = 4'd7;
   localparam logic [3:0] S_DONE     = 4'd8;

   localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

   logic [3:0] state_q, state_d;
   logic [2:0] slot_q, slot_d;

   logic [7:0] y_q, tile_q, attr_q, x_q, lo_q, hi_q;

   logic        empty;
   logic        plane;
   logic [2:0]  row8;
   logic [3:0]  rr;
   logic [12:0] addr13;
   logic [1:0]  field;
   logic [7:0]  pix1, pix2, x_load;

   // The shifter emits bit 0 first (leftmost pixel), while CHR stores the
   // leftmost pixel in bit 7, so unflipped bytes must be mirrored.
   function automatic logic [7:0] bit_rev(input logic [7:0] b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = b[7-i];
      return r;
   endfunction

   assign empty = (y_q == 8'hFF);

   // Next-state logic
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_RD_Y;
               slot_d  = 3'd0;
            end
         end
         S_RD_Y:     state_d = S_RD_TILE;
         S_RD_TILE:  state_d = S_RD_ATTR;
         S_RD_ATTR:  state_d = S_RD_X;
         S_RD_X:     state_d = empty ? S_LOAD : S_FETCH_LO;
         S_FETCH_LO: if (bus.i_chr_ack) state_d = S_FETCH_HI;
         S_FETCH_HI: if (bus.i_chr_ack) state_d = S_LOAD;
         S_LOAD: begin
            if (slot_q == LAST_SLOT) begin
               state_d = S_DONE;
            end else begin
               slot_d  = slot_q + 3'd1;
               state_d = S_RD_Y;
            end
         end
         S_DONE:     state_d = S_IDLE;
         default:    state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         slot_q  <= 3'd0;
      end else if (ce) begin
         state_q <= state_d;
         slot_q  <= slot_d;
      end
   end

   // Each read state captures the byte addressed by the state before it.
   // X is re-captured on every FETCH_LO cycle; the address still points at
   // the X field there, so the value does not change while waiting for ack.
   always_ff @(posedge clk) begin
      if (ce) begin
         case (state_q)
            S_RD_TILE:  y_q    <= bus.i_temp_data;
            S_RD_ATTR:  tile_q <= bus.i_temp_data;
            S_RD_X:     attr_q <= bus.i_temp_data;
            S_FETCH_LO: begin
               x_q <= bus.i_temp_data;
               if (bus.i_chr_ack) lo_q <= bus.i_chr_data;
            end
            S_FETCH_HI: if (bus.i_chr_ack) hi_q <= bus.i_chr_data;
            default: ;
         endcase
      end
   end

   // Secondary OAM address: Y/tile/attr in the read states, X everywhere else
   // in the active sequence so the X byte stays on the data bus.
   always_comb begin
      case (state_q)
         S_RD_Y:    field = 2'd0;
         S_RD_TILE: field = 2'd1;
         S_RD_ATTR: field = 2'd2;
         default:   field = 2'd3;
      endcase
   end

   assign bus.o_temp_addr = (state_q == S_IDLE) ? 5'd0 : {slot_q, field};

   // Row selection; 7-r and 15-r are plain bit inversions at these widths.
   assign row8  = attr_q[7] ? ~y_q[2:0] : y_q[2:0];
   assign rr    = attr_q[7] ? ~y_q[3:0] : y_q[3:0];
   assign plane = (state_q == S_FETCH_HI);

   assign addr13 = i_obj_size ? {tile_q[0], tile_q[7:1], rr[3], plane, rr[2:0]}
                              : {i_spr_table, tile_q, plane, row8};

   assign bus.o_chr_req  = (state_q == S_FETCH_LO) || (state_q == S_FETCH_HI);
   assign bus.o_chr_addr = bus.o_chr_req ? CHR_AW'(addr13) : '0;

   // Empty slots load transparent pixels; their X byte is still on the
   // temp bus during LOAD because no fetch state re-captured it.
   assign pix1   = empty ? 8'h00 : (attr_q[6] ? lo_q : bit_rev(lo_q));
   assign pix2   = empty ? 8'h00 : (attr_q[6] ? hi_q : bit_rev(hi_q));
   assign x_load = empty ? bus.i_temp_data : x_q;

   assign o_load    = (state_q == S_LOAD) ? 4'b1111 : 4'b0000;
   assign o_load_in = (state_q == S_LOAD) ? {pix1, pix2, x_load, attr_q[1:0], attr_q[5]}
                                          : 27'd0;
   assign o_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
   assign o_done    = (state_q == S_DONE);

endmodule

// File: tb/tb_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tb_sprite_fetch
// Bench for sprite_fetch: secondary OAM and CHR memory models with adjustable
// ack delay and clock-enable pattern, directed cases plus randomized frames
// compared against a slot-level reference model.
// -----------------------------------------------------------------------------
module tb_sprite_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, ce, start, obj_size, spr_table;
   logic [3:0]  load;
   logic [26:0] load_in;
   logic        busy, done;

   sprite_fetch_if #(.CHR_AW(14)) bus ();

   sprite_fetch #(.NUM_SLOTS(8), .CHR_AW(14)) dut (
      .clk        (clk),
      .i_rst_n    (rst_n),
      .ce         (ce),
      .i_start    (start),
      .i_obj_size (obj_size),
      .i_spr_table(spr_table),
      .bus        (bus),
      .o_load     (load),
      .o_load_in  (load_in),
      .o_busy     (busy),
      .o_done     (done)
   );

   // ---------------- memory models ----------------
   logic [7:0] oam [32];
   logic [7:0] chr [16384];
   logic [7:0] temp_q;
   int         wait_cnt;
   int         ack_delay;
   bit         toggle;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         temp_q   <= 8'h00;
         wait_cnt <= 0;
      end else if (ce) begin
         temp_q <= oam[bus.o_temp_addr];
         if (bus.o_chr_req && !bus.i_chr_ack) wait_cnt <= wait_cnt + 1;
         else                                 wait_cnt <= 0;
      end
   end

   assign bus.i_temp_data = temp_q;
   assign bus.i_chr_ack   = bus.o_chr_req && (wait_cnt >= ack_delay);
   assign bus.i_chr_data  = chr[bus.o_chr_addr];

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int exp_load[$];
   int exp_addr[$];
   int exp_cycles;

   function automatic int mirror8(input int b);
      int r;
      r = 0;
      for (int i = 0; i < 8; i++) if (((b >> i) & 1) == 1) r += 1 << (7 - i);
      return r;
   endfunction

   task automatic build_expect();
      int y, t, a, x, row, base, p1, p2;
      exp_load.delete();
      exp_addr.delete();
      exp_cycles = 1;
      for (int s = 0; s < 8; s++) begin
         y = oam[4*s]; t = oam[4*s+1]; a = oam[4*s+2]; x = oam[4*s+3];
         if (y == 255) begin
            p1 = 0; p2 = 0;
            exp_cycles += 5;
         end else begin
            if (!obj_size) begin
               row = y % 8;
               if (a >= 128) row = 7 - row;
               base = (spr_table ? 4096 : 0) + t * 16 + row;
            end else begin
               row = y % 16;
               if (a >= 128) row = 15 - row;
               base = (t % 2) * 4096 + (t / 2) * 32 + (row / 8) * 16 + (row % 8);
            end
            exp_addr.push_back(base);
            exp_addr.push_back(base + 8);
            p1 = chr[base];
            p2 = chr[base + 8];
            if (((a / 64) % 2) == 0) begin
               p1 = mirror8(p1);
               p2 = mirror8(p2);
            end
            exp_cycles += 7;
         end
         exp_load.push_back(p1 * (1 << 19) + p2 * (1 << 11) + x * 8 + (a % 4) * 2 + ((a / 32) % 2));
      end
   endtask

   // ---------------- monitor / driver ----------------
   int got_load[$];
   int got_addr[$];
   int done_cnt, done_at, ce_idx;
   bit pend;
   logic [13:0] pend_addr;

   task automatic monitor();
      if (ce) begin
         ce_idx++;
         if (load != 4'h0) begin
            chk("load_strobe", 32'(load), 32'hF);
            got_load.push_back(int'(load_in));
         end
         if (done) begin
            done_cnt++;
            if (done_at < 0) done_at = ce_idx;
         end
      end
      if (pend && rst_n) begin
         chk("req_held", 32'(bus.o_chr_req), 32'd1);
         chk("addr_stable", 32'(bus.o_chr_addr), 32'(pend_addr));
      end
      if (bus.o_chr_req && ce && bus.i_chr_ack) begin
         got_addr.push_back(int'(bus.o_chr_addr));
         pend = 1'b0;
      end else if (bus.o_chr_req) begin
         pend      = 1'b1;
         pend_addr = bus.o_chr_addr;
      end else begin
         pend = 1'b0;
      end
   endtask

   task automatic tick(input bit st);
      @(negedge clk);
      if (st) ce = 1'b1;
      else    ce = toggle ? ~ce : 1'b1;
      start = st;
      #1;
      monitor();
   endtask

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      return -1;
   endfunction

   task automatic clear_oam();
      for (int i = 0; i < 32; i++) oam[i] = 8'hFF;
   endtask

   task automatic set_slot(input int s, input int y, input int t, input int a, input int x);
      oam[4*s] = 8'(y); oam[4*s+1] = 8'(t); oam[4*s+2] = 8'(a); oam[4*s+3] = 8'(x);
   endtask

   task automatic fill_random(input int empty_pct);
      for (int s = 0; s < 8; s++) begin
         oam[4*s]   = ($urandom_range(0, 99) < empty_pct) ? 8'hFF : 8'($urandom_range(0, 254));
         oam[4*s+1] = 8'($urandom);
         oam[4*s+2] = 8'($urandom);
         oam[4*s+3] = 8'($urandom);
      end
   endtask

   task automatic begin_frame(input int dly, input bit tog);
      ack_delay = dly;
      toggle    = tog;
      build_expect();
      got_load.delete();
      got_addr.delete();
      done_cnt = 0;
      done_at  = -1;
      ce_idx   = -1;
      pend     = 1'b0;
   endtask

   task automatic run_frame(input int dly, input bit tog, input bit mid);
      begin_frame(dly, tog);
      tick(1'b1);
      tick(1'b0);
      chk("busy_run", 32'(busy), 32'd1);
      for (int t = 0; t < 3000 && done_cnt == 0; t++) tick(mid && t == 30);
      repeat (20) tick(1'b0);
      chk("done_once", done_cnt, 1);
      chk("busy_end", 32'(busy), 32'd0);
      chk("n_loads", got_load.size(), 8);
      for (int i = 0; i < 8; i++) chk($sformatf("load_word%0d", i), qat(got_load, i), exp_load[i]);
      chk("n_fetch", got_addr.size(), exp_addr.size());
      for (int i = 0; i < exp_addr.size(); i++)
         chk($sformatf("chr_addr%0d", i), qat(got_addr, i), exp_addr[i]);
      if (dly == 0 && !tog) chk("latency", done_at, exp_cycles);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit reached;
      rst_n = 1'b0; ce = 1'b1; start = 1'b0; toggle = 1'b0; ack_delay = 0;
      obj_size = 1'b0; spr_table = 1'b0; pend = 1'b0;
      done_cnt = 0; done_at = -1; ce_idx = -1;
      for (int i = 0; i < 16384; i++) chr[i] = 8'($urandom);
      clear_oam();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_req",       32'(bus.o_chr_req),   32'd0);
      chk("rst_load",      32'(load),            32'd0);
      chk("rst_load_in",   32'(load_in),         32'd0);
      chk("rst_busy",      32'(busy),            32'd0);
      chk("rst_done",      32'(done),            32'd0);
      chk("rst_temp_addr", 32'(bus.o_temp_addr), 32'd0);
      chk("rst_chr_addr",  32'(bus.o_chr_addr),  32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 8x8 basic slot, other slots empty
      chr[14'h0423] = 8'h80; chr[14'h042B] = 8'h01;
      set_slot(0, 8'h03, 8'h42, 8'h00, 8'h10);
      run_frame(0, 1'b0, 1'b0);
      chk("d_lo_addr", qat(got_addr, 0), 32'h0423);
      chk("d_hi_addr", qat(got_addr, 1), 32'h042B);
      chk("d_word",    qat(got_load, 0), 32'h00C0080);

      set_slot(0, 8'h03, 8'h42, 8'h40, 8'h10);
      run_frame(0, 1'b0, 1'b0);
      chk("d_hflip_word", qat(got_load, 0), 32'h4000880);

      set_slot(0, 8'h03, 8'h42, 8'h80, 8'h10);
      run_frame(0, 1'b0, 1'b0);
      chk("d_vflip_lo", qat(got_addr, 0), 32'h0424);
      chk("d_vflip_hi", qat(got_addr, 1), 32'h042C);

      set_slot(0, 8'h03, 8'h42, 8'h23, 8'h10);
      run_frame(0, 1'b0, 1'b0);
      chk("d_pal_prio", qat(got_load, 0) % 8, 7);

      // 8x16
      obj_size = 1'b1;
      set_slot(0, 8'h09, 8'h43, 8'h00, 8'h20);
      run_frame(0, 1'b0, 1'b0);
      chk("d16_lo", qat(got_addr, 0), 32'h1431);
      spr_table = 1'b1;
      run_frame(0, 1'b0, 1'b0);
      chk("d16_tbl", qat(got_addr, 0), 32'h1431);
      spr_table = 1'b0;
      set_slot(0, 8'h09, 8'h43, 8'h80, 8'h20);
      run_frame(0, 1'b0, 1'b0);
      chk("d16_vflip", qat(got_addr, 0), 32'h1426);

      // all full, zero wait: 57-cycle window
      obj_size = 1'b0;
      fill_random(0);
      run_frame(0, 1'b0, 1'b0);
      chk("full_latency", done_at, 57);

      // slow memory, ce toggling
      fill_random(0);
      run_frame(3, 1'b1, 1'b0);

      // randomized frames, one with a stray start mid-sequence
      for (int f = 0; f < 8; f++) begin
         obj_size  = 1'($urandom);
         spr_table = 1'($urandom);
         fill_random(35);
         run_frame($urandom_range(0, 3), 1'($urandom), f == 2);
      end

      // reset during FETCH_HI of slot 4
      obj_size = 1'b0; spr_table = 1'b0;
      fill_random(0);
      begin_frame(3, 1'b1);
      tick(1'b1);
      reached = 1'b0;
      for (int t = 0; t < 3000; t++) begin
         if (got_addr.size() == 9 && bus.o_chr_req && int'(bus.o_chr_addr) == exp_addr[9]) begin
            reached = 1'b1;
            break;
         end
         tick(1'b0);
      end
      chk("rst_reach", 32'(reached), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req",  32'(bus.o_chr_req), 32'd0);
      chk("mid_rst_load", 32'(load),          32'd0);
      chk("mid_rst_busy", 32'(busy),          32'd0);
      chk("loads_before", got_load.size(), 4);
      repeat (3) tick(1'b0);
      chk("rst_no_load", got_load.size(), 4);
      chk("rst_no_done", done_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pend  = 1'b0;
      run_frame(3, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Upstream feeder of the 8-entry sprite shifter set. Runs during the sprite-fetch window (line cycles 256-319).
- Walks the 32-byte secondary OAM (sprite temp RAM) slot by slot and fetches each sprite's two pattern bytes from CHR memory.
- Applies flip and size rules, then pushes one 27-bit load word per slot into the shifter chain.
- The first slot pushed ends up in shifter 0, the highest priority.

Parameters:
- NUM_SLOTS, 8, sprites per line; fixed by the shifter chain length.
- CHR_AW, 14, CHR address width; bit 13 always driven 0.

Ports:
- clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- ce  in  1  clock enable; all state, captures and strobes advance only when ce=1
- i_start  in  1  one-ce-cycle pulse at cycle 256 of a rendering line
- i_obj_size  in  1  1 = 8x16 sprites
- i_spr_table  in  1  sprite pattern table select for 8x8 mode
- o_temp_addr  out  5  secondary OAM address {slot[2:0], field[1:0]}; field order is 0=Y offset, 1=tile, 2=attr, 3=X
- i_temp_data  in  8  secondary OAM read data, valid on the ce cycle after the address
- o_chr_req  out  1  CHR read request, level
- o_chr_addr  out  CHR_AW  CHR byte address
- i_chr_ack  in  1  data valid; sampled on ce cycles while req=1
- i_chr_data  in  8  CHR read data
- o_load  out  4  shifter load strobe; 4'b1111 for one ce cycle per slot, otherwise 0
- o_load_in  out  27  {pix1[7:0], pix2[7:0], x[7:0], pal[1:0], prio}
- o_busy  out  1  high from the accepted start until done
- o_done  out  1  one-ce-cycle pulse after slot 7 is loaded

Behaviour:
- Reset (async): state IDLE, slot=0. o_chr_req=0, o_load=0, o_load_in=0, o_busy=0, o_done=0, o_temp_addr=0, o_chr_addr=0.
- States and transitions:
  - IDLE: on i_start, go to RD_Y with slot=0 and o_busy=1.
  - RD_Y → RD_TILE → RD_ATTR → RD_X: each drives {slot, field}. Each following state captures the byte addressed in the previous one. FETCH_LO or the empty-slot path captures X.
  - FETCH_LO: drives req and the low-plane address. On ack, capture data and go to FETCH_HI.
  - FETCH_HI: drives req and the high-plane address. On ack, capture data and go to LOAD.
  - LOAD: o_load=4'b1111 for exactly one ce cycle. If slot==7, go to DONE; otherwise slot+1 and go to RD_Y.
  - DONE: o_done=1 for one ce cycle and o_busy=0, then IDLE.
- Empty slot: if the captured Y byte is 0xFF, skip both fetches (no req). Load pix1=pix2=0, x=captured X, pal/prio from the captured attr.
- Row selection, with r = Y[3:0]:
  - 8x8: row = Y[2:0], or 7-Y[2:0] if attr[7] (vertical flip).
  - 8x16: rr = r, or 15-r if attr[7].
- Address, with plane 0=low and 1=high:
  - 8x8: {1'b0, i_spr_table, tile[7:0], plane, row[2:0]}.
  - 8x16: {1'b0, tile[0], tile[7:1], rr[3], plane, rr[2:0]}.
- Pixel order: the shifter outputs bit 0 first, i.e. leftmost.
  - attr[6]=0: each fetched byte is bit-reversed before loading.
  - attr[6]=1 (horizontal flip): the byte loads unreversed.
- Load word fields: pal = attr[1:0], prio = attr[5], x = X byte.
- Handshake:
  - req and address stay stable until an ack is sampled.
  - req drops in the cycle after ack unless the next state is a fetch; FETCH_LO→FETCH_HI may keep req high with a new address.
  - Memory holds ack/data until ce samples them.
- Latency, zero-wait memory with ack in the same cycle: 7 ce cycles per full slot, 5 per empty slot. Done fires 57 ce cycles after start in the all-full case, inside the 64-cycle window.
- i_start while busy is ignored. i_obj_size and i_spr_table are sampled live and must be stable during the window.
- Reset asserted mid-fetch aborts immediately with no partial load strobe. The shifter set keeps whatever was already pushed.

Test Plan:
- 8x8, table 0, slot0 {Y=03, tile=42, attr=00, X=10}, CHR lo=80 hi=01, other slots Y=FF:
  - Required: addresses 0x0423 then 0x042B.
  - Required first load_in = {01, 80, 10, 2'b00, 0}.
  - Required 7 further empty loads with no req, then o_done.
- Same slot with attr=0x40 (hflip) → pix1=80, pix2=01. With attr=0x80 (vflip) → addresses 0x0424/0x042C. With attr=0x23 → pal=3, prio=1.
- 8x16, tile=43, Y=09, attr=00:
  - Required: lo address 0x1431.
  - With attr=0x80 → 0x1426.
  - i_spr_table has no effect.
- Memory ack delayed 3 ce cycles per fetch, with ce toggling 1/0:
  - Required: req and address stable throughout, exactly one load pulse per slot, 8 pulses total, order slot0..slot7.
- Assert i_rst_n=0 during FETCH_HI of slot 4:
  - Required: req=0, load=0, busy=0 immediately.
  - A subsequent i_start restarts at slot 0.
- i_start pulsed again mid-sequence → ignored; done count stays 1.
